// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver with show-ahead receive FIFO
// and sticky parity, framing and overflow error flags.
module uart_rx #(
  parameter int UART_DATA_WIDTH        = 8,
  parameter int UART_RX_FIFO_DEPTH     = 8,
  parameter int UART_RX_FIFO_PTR_WIDTH = 4
) (
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic                       rx_baud_pulse,
  input  logic                       UART_RX,
  input  logic                       rx_data_reg_rd,
  input  logic                       data_bits,
  input  logic                       parity_en,
  input  logic                       parity_odd0_even1,
  input  logic                       rx_err_clr,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_ready,
  output logic                       parity_err,
  output logic                       framing_err,
  output logic                       overflow_err
);

  localparam int BW     = $clog2(UART_DATA_WIDTH);
  localparam int ADDR_W = UART_RX_FIFO_PTR_WIDTH - 1;
  localparam logic [BW-1:0] LAST8 = BW'(UART_DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST7 = BW'(UART_DATA_WIDTH - 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                       r_state;
  logic                         r_rx_meta;
  logic                         r_rxs;
  logic                         r_armed;
  logic [3:0]                   r_tick;
  logic [BW-1:0]                r_bit_cnt;
  logic [UART_DATA_WIDTH-1:0]   r_shift;
  logic                         r_bits8;
  logic                         r_par_en;
  logic                         r_par_even;
  logic                         r_bad;
  logic                         r_parity_err;
  logic                         r_framing_err;
  logic                         r_overflow_err;
  logic [UART_RX_FIFO_PTR_WIDTH-1:0] r_wr_ptr;
  logic [UART_RX_FIFO_PTR_WIDTH-1:0] r_rd_ptr;
  logic [UART_DATA_WIDTH-1:0]   r_mem [UART_RX_FIFO_DEPTH];

  logic w_tick_end;
  logic w_mid_bit;
  logic w_par_exp;
  logic w_perr_set;
  logic w_ferr_set;
  logic w_push;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovf_set;

  assign w_tick_end = rx_baud_pulse && (r_tick == 4'd15);
  assign w_mid_bit  = rx_baud_pulse && (r_tick == 4'd7);
  assign w_par_exp  = r_par_even ? (^r_shift) : ~(^r_shift);
  assign w_perr_set = (r_state == S_PARITY) && w_tick_end && (r_rxs != w_par_exp);
  assign w_ferr_set = (r_state == S_STOP) && w_tick_end && !r_rxs;
  assign w_push     = (r_state == S_STOP) && w_tick_end && r_rxs && !r_bad;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_tick     <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_bits8    <= 1'b1;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      if (rx_baud_pulse) r_tick <= r_tick + 4'd1;
      case (r_state)
        S_IDLE: begin
          // A line stuck low after a bad stop bit must go high before the next start counts
          if (rx_baud_pulse) begin
            if (!r_armed) begin
              r_armed <= r_rxs;
            end else if (!r_rxs) begin
              r_state <= S_START;
              r_tick  <= '0;
            end
          end
        end
        S_START: begin
          if (w_mid_bit) begin
            if (!r_rxs) begin
              r_state    <= S_DATA;
              r_tick     <= '0;
              r_bit_cnt  <= '0;
              r_shift    <= '0;
              r_bad      <= 1'b0;
              r_bits8    <= data_bits;
              r_par_en   <= parity_en;
              r_par_even <= parity_odd0_even1;
            end else begin
              r_state <= S_IDLE;
              r_armed <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_tick_end) begin
            r_shift[r_bit_cnt] <= r_rxs;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == (r_bits8 ? LAST8 : LAST7))
              r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_tick_end) begin
            if (w_perr_set) r_bad <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick_end) begin
            if (!r_rxs) r_bad <= 1'b1;
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign w_pop     = rx_data_reg_rd && !w_empty;
  // A pop on the same edge frees the slot the write lands in
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= r_shift;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_parity_err   <= 1'b0;
      r_framing_err  <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_parity_err   <= w_perr_set ? 1'b1 : (rx_err_clr ? 1'b0 : r_parity_err);
      r_framing_err  <= w_ferr_set ? 1'b1 : (rx_err_clr ? 1'b0 : r_framing_err);
      r_overflow_err <= w_ovf_set  ? 1'b1 : (rx_err_clr ? 1'b0 : r_overflow_err);
    end
  end

  assign rx_ready     = !w_empty;
  assign rx_data      = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign parity_err   = r_parity_err;
  assign framing_err  = r_framing_err;
  assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx.
module tb_uart_rx;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic       rx_baud_pulse = 1'b0;
  logic       UART_RX;
  logic       rx_data_reg_rd;
  logic       data_bits;
  logic       parity_en;
  logic       parity_odd0_even1;
  logic       rx_err_clr;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pc       = 0;

  uart_rx #(
    .UART_DATA_WIDTH(8), .UART_RX_FIFO_DEPTH(8), .UART_RX_FIFO_PTR_WIDTH(4)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .rx_baud_pulse(rx_baud_pulse), .UART_RX(UART_RX),
    .rx_data_reg_rd(rx_data_reg_rd), .data_bits(data_bits), .parity_en(parity_en),
    .parity_odd0_even1(parity_odd0_even1), .rx_err_clr(rx_err_clr), .rx_data(rx_data),
    .rx_ready(rx_ready), .parity_err(parity_err), .framing_err(framing_err),
    .overflow_err(overflow_err)
  );

  always #5 PCLK = ~PCLK;

  // Baud strobe: one PCLK in four, changed on the falling edge
  initial begin
    forever begin
      @(negedge PCLK);
      pc = pc + 1;
      rx_baud_pulse = (pc % 4 == 0);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       bits8;
    logic       pen;
    logic       even;
    logic       flip;
    logic       stop;
    logic       exp_push;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge PCLK); while (!rx_baud_pulse);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    UART_RX = b;
    wait_pulses(n);
  endtask

  function automatic logic par_bit(input logic [7:0] d, input logic bits8, input logic even);
    logic [7:0] w;
    w = bits8 ? d : {1'b0, d[6:0]};
    return even ? (^w) : ~(^w);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic bits8, input logic pen,
                            input logic even, input logic flip, input logic stop,
                            input int stop_pulses);
    data_bits = bits8;
    parity_en = pen;
    parity_odd0_even1 = even;
    drive_bit(1'b1, 4);
    drive_bit(1'b0, 16);
    for (int i = 0; i < (bits8 ? 8 : 7); i++) drive_bit(d[i], 16);
    if (pen) drive_bit(par_bit(d, bits8, even) ^ flip, 16);
    drive_bit(stop, stop_pulses);
    UART_RX = 1'b1;
  endtask

  task automatic strobe_next_pulse(input logic rd, input logic clr);
    do begin @(negedge PCLK); #1; end while (!rx_baud_pulse);
    rx_data_reg_rd = rd;
    rx_err_clr = clr;
    @(posedge PCLK);
    #1;
    rx_data_reg_rd = 1'b0;
    rx_err_clr = 1'b0;
  endtask

  task automatic pop();
    @(negedge PCLK); rx_data_reg_rd = 1'b1;
    @(negedge PCLK); rx_data_reg_rd = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge PCLK); rx_err_clr = 1'b1;
    @(negedge PCLK); rx_err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h35, 0, 0, 0, 0, 1, 1, 8'h35, 0, 0};
    vecs[2] = '{8'h3C, 1, 1, 1, 0, 1, 1, 8'h3C, 0, 0};
    vecs[3] = '{8'h81, 1, 1, 0, 0, 1, 1, 8'h81, 0, 0};
    vecs[4] = '{8'h35, 0, 1, 1, 1, 1, 0, 8'h00, 1, 0};
    vecs[5] = '{8'h3C, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1};
    vecs[6] = '{8'hB5, 0, 1, 0, 0, 1, 1, 8'h35, 0, 0};
    vecs[7] = '{8'h55, 1, 0, 0, 0, 1, 1, 8'h55, 0, 0};
    vecs[8] = '{8'h6B, 1, 1, 1, 1, 1, 0, 8'h00, 1, 0};

    PRESETN = 1'b0;
    UART_RX = 1'b1;
    rx_data_reg_rd = 1'b0;
    data_bits = 1'b1;
    parity_en = 1'b0;
    parity_odd0_even1 = 1'b0;
    rx_err_clr = 1'b0;
    #1;
    check("reset_ready", rx_ready, 0);
    check("reset_data", rx_data, 0);
    check("reset_flags", {parity_err, framing_err, overflow_err}, 0);
    repeat (4) @(negedge PCLK);
    PRESETN = 1'b1;

    // 8N1 0xA5 with edge-exact ready timing
    send_frame(8'hA5, 1, 0, 0, 0, 1, 8);
    check("a5_ready_before_stop", rx_ready, 0);
    wait_pulses(1);
    check("a5_ready_at_stop", rx_ready, 1);
    check("a5_data", rx_data, 8'hA5);
    wait_pulses(7);
    check("a5_flags", {parity_err, framing_err, overflow_err}, 0);
    pop();
    #1;
    check("a5_pop_empty", rx_ready, 0);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].data, vecs[v].bits8, vecs[v].pen, vecs[v].even,
                 vecs[v].flip, vecs[v].stop, 16);
      check($sformatf("vec%0d_ready", v), rx_ready, vecs[v].exp_push);
      if (vecs[v].exp_push) check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_perr", v), parity_err, vecs[v].exp_perr);
      check($sformatf("vec%0d_ferr", v), framing_err, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovf", v), overflow_err, 0);
      if (rx_ready) pop();
      clear_errs();
      #1;
      check($sformatf("vec%0d_cleared", v), {rx_ready, parity_err, framing_err}, 0);
    end

    // Short low glitch while idle
    drive_bit(1'b1, 4);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 24);
    check("glitch_ready", rx_ready, 0);
    check("glitch_flags", {parity_err, framing_err, overflow_err}, 0);
    send_frame(8'h55, 1, 0, 0, 0, 1, 16);
    check("post_glitch_data", rx_data, 8'h55);
    pop();

    // Fill buffer, then overflow with a same-edge clear (set must win)
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1, 0, 0, 0, 1, 16);
    check("full_ready", rx_ready, 1);
    check("full_no_ovf", overflow_err, 0);
    send_frame(8'h09, 1, 0, 0, 0, 1, 8);
    strobe_next_pulse(1'b0, 1'b1);
    wait_pulses(7);
    check("ovf_set_wins", overflow_err, 1);
    check("ovf_head", rx_data, 8'h01);
    clear_errs();
    #1;
    check("ovf_cleared", overflow_err, 0);
    send_frame(8'h09, 1, 0, 0, 0, 1, 8);
    strobe_next_pulse(1'b1, 1'b0);
    wait_pulses(7);
    check("full_pop_push_ovf", overflow_err, 0);
    check("full_pop_push_head", rx_data, 8'h02);
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("drain_%0d", i), rx_data, 8'(i));
      pop();
    end
    #1;
    check("drain_empty", rx_ready, 0);
    pop();
    #1;
    check("empty_pop_ignored", rx_ready, 0);
    send_frame(8'h77, 1, 0, 0, 0, 1, 16);
    check("after_empty_pop_data", rx_data, 8'h77);

    // Reset in the middle of data bit 3 of 0xFF, with state to discard
    send_frame(8'h3C, 1, 0, 0, 0, 0, 16);
    check("pre_reset_state", {rx_ready, framing_err}, 2'b11);
    drive_bit(1'b1, 4);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    PRESETN = 1'b0;
    #1;
    check("midframe_reset_ready", rx_ready, 0);
    check("midframe_reset_data", rx_data, 0);
    check("midframe_reset_flags", {parity_err, framing_err, overflow_err}, 0);
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    drive_bit(1'b1, 120);
    check("post_reset_no_push", {rx_ready, parity_err, framing_err, overflow_err}, 0);
    send_frame(8'h0F, 1, 0, 0, 0, 1, 16);
    check("post_reset_ready", rx_ready, 1);
    check("post_reset_data", rx_data, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameters: UART_DATA_WIDTH, 8, receive word width; UART_RX_FIFO_DEPTH, 8, receive buffer entries; UART_RX_FIFO_PTR_WIDTH, 4, buffer pointer width including wrap bit.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-low. Ports:
- PCLK  in  1  sole clock, all state on rising edge
- PRESETN  in  1  asynchronous active-low reset
- rx_baud_pulse  in  1  one-PCLK strobe at 16x bit rate
- UART_RX  in  1  serial line, asynchronous to PCLK, idle high
- rx_data_reg_rd  in  1  pop strobe for head of receive buffer
- data_bits  in  1  0 = 7 data bits, 1 = 8 data bits
- parity_en  in  1  1 = parity bit follows data
- parity_odd0_even1  in  1  0 = odd parity, 1 = even parity
- rx_err_clr  in  1  clears all sticky error flags
- rx_data  out  8  head entry of receive buffer (show-ahead)
- rx_ready  out  1  receive buffer not empty
- parity_err  out  1  sticky parity error
- framing_err  out  1  sticky framing error
- overflow_err  out  1  sticky overflow error

Function
REQ-003 SHALL pass UART_RX through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-004 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP with a 4-bit tick counter advanced only on rx_baud_pulse.
REQ-005 IDLE: the FSM SHALL arm only after sampling rxs=1 on a pulse. When armed and rxs=0 on a pulse, it SHALL go to START with the tick counter cleared.
REQ-006 START: on the 8th pulse (mid-bit), rxs=0 SHALL go to DATA and clear the tick counter. rxs=1 SHALL count as a glitch: return to IDLE with no flag and no write.
REQ-007 DATA: every 16th pulse SHALL sample rxs into bit position bit_cnt, LSB first. After bit 6 (data_bits=0) or bit 7 (data_bits=1), the FSM SHALL go to PARITY if parity_en, else STOP. In 7-bit mode, bit 7 of the stored word SHALL be 0.
REQ-008 PARITY: the 16th pulse SHALL sample the parity bit. Expected value is ^data when parity_odd0_even1=1 and ~^data when 0, computed over the stored 8-bit word. A mismatch SHALL mark the frame bad.
REQ-009 STOP: the 16th pulse SHALL sample the stop bit, and the FSM SHALL return to IDLE disarmed.
- rxs=0 SHALL set framing_err and mark the frame bad.
- A good frame SHALL be pushed on that same PCLK.
- A bad frame SHALL be discarded.
REQ-010 Control inputs (data_bits, parity_en, parity_odd0_even1) SHALL be sampled once on the START to DATA transition and held for the frame.
REQ-011 Receive buffer: FIFO of UART_RX_FIFO_DEPTH entries; pointers wrap modulo depth; full/empty SHALL be distinguished by the MSB of the pointer.
REQ-012 rx_ready SHALL assert the PCLK after a push into an empty buffer. rx_data SHALL show the head entry whenever rx_ready=1. rx_data value is don't-care when empty.
REQ-013 rx_data_reg_rd with rx_ready=1 SHALL pop one entry. rx_data_reg_rd while empty SHALL be ignored, with no pointer change.
REQ-014 A push while full SHALL drop the byte and set overflow_err, unless a pop occurs on the same PCLK. In that case both SHALL take effect and the count SHALL remain at depth.
REQ-015 A push and pop on the same PCLK with 0<count<depth SHALL leave the count unchanged.
REQ-016 Error flags SHALL be sticky until rx_err_clr. If a set and a clear occur on the same PCLK, the set SHALL win.
REQ-017 Frames SHALL never be truncated by buffer state. Reception SHALL continue while full.

Reset
REQ-018 PRESETN low SHALL force, asynchronously:
- FSM to IDLE, disarmed; counters to 0
- synchronizer to 1; buffer empty (rx_ready=0)
- rx_data=0; all error flags 0
REQ-019 Reset mid-frame SHALL discard the partial frame with no push and no flag.

Verification
REQ-020 8N1, byte 0xA5 at 16x pulses -> rx_ready rises one PCLK after the stop sample, rx_data=0xA5, no flags; one pop -> rx_ready=0.
REQ-021 7E1, data_bits=0, parity_en=1, even, byte 0x35, parity bit deliberately inverted -> no push, parity_err=1; rx_err_clr -> parity_err=0.
REQ-022 8N1 byte 0x3C with stop bit driven 0 -> framing_err=1, no push. Line then held high, then next frame 0x55 -> received correctly.
REQ-023 Low glitch of 4 baud pulses while idle -> FSM returns to IDLE, no push, no flag.
REQ-024 Nine 8N1 frames 0x01..0x09 with no pops -> eight entries 0x01..0x08, overflow_err=1. Ninth frame with a pop on its push cycle -> no overflow, head=0x02.
REQ-025 PRESETN asserted during DATA bit 3 of 0xFF -> all outputs at reset values. After release, next frame 0x0F -> received as 0x0F.
